// File: rtl/unidade_despacho_pkg.sv
// Shared constants for the dispatch unit: free-register tag, pending-operand
// marker, NOP opcode and the instruction field positions.
package unidade_despacho_pkg;
  localparam int          FREE_REGISTER   = 0;
  localparam logic [15:0] V_SEM_VALOR_DEF = 16'hFFF0;
  localparam logic [2:0]  OP_NOP          = 3'b000;
  localparam int          OP_LSB          = 13;
  localparam int          RI_LSB          = 10;
  localparam int          RJ_LSB          = 7;
  localparam int          RK_LSB          = 4;
  localparam int          FIELD_W         = 3;
endpackage

// File: rtl/unidade_despacho_param_seletor_rr.sv
// Round-robin picker: first set bit of mask at or after ptr, wrapping around.
module seletor_rr #(
  parameter int N     = 4,
  parameter int PTR_W = 2
) (
  input  logic [N-1:0]     mask,
  input  logic [PTR_W-1:0] ptr,
  output logic             found,
  output logic [PTR_W-1:0] index
);
  always_comb begin
    found = 1'b0;
    index = '0;
    for (int k = 0; k < N; k++) begin
      automatic int idx = (int'(ptr) + k) % N;
      if (!found && mask[idx]) begin
        found = 1'b1;
        index = PTR_W'(idx);
      end
    end
  end
endmodule

// File: rtl/unidade_despacho_param.sv
// Tomasulo dispatch unit: picks a free reservation station round-robin,
// resolves operands against register status / CDB, and writes the new mapping.
module unidade_despacho_param
  import unidade_despacho_pkg::*;
#(
  parameter int                NUM_RS      = 4,
  parameter int                NUM_REGS    = 8,
  parameter int                DATA_W      = 16,
  parameter int                TAG_W       = 3,
  parameter logic [DATA_W-1:0] V_SEM_VALOR = V_SEM_VALOR_DEF
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic                     Inst_Valid,
  input  logic [15:0]              Instrucao_Despachada,
  output logic                     Pop,
  input  logic [NUM_REGS*TAG_W-1:0]  Rs_Qi,
  input  logic [NUM_REGS*DATA_W-1:0] Rs_Qi_data,
  input  logic [NUM_RS-1:0]        Busy_RS,
  input  logic                     CDB_Valid,
  input  logic [TAG_W-1:0]         CDB_Tag,
  input  logic [DATA_W-1:0]        CDB_Data,
  output logic [DATA_W-1:0]        Vj,
  output logic [DATA_W-1:0]        Vk,
  output logic [TAG_W-1:0]         Qj,
  output logic [TAG_W-1:0]         Qk,
  output logic [2:0]               Ufop,
  output logic [NUM_RS-1:0]        Enable_VQ,
  output logic                     R_enable_despacho,
  output logic [2:0]               R_target_despacho,
  output logic [TAG_W-1:0]         R_res_station_despacho,
  output logic [15:0]              Stall_Count
);
  localparam int PTR_W = $clog2(NUM_RS);

  // Handshake: the queue head is consumed in any cycle where Inst_Valid and Pop are both high.
  logic [2:0]       opcode, ri, rj, rk;
  logic             is_nop, found, dispatch, stall;
  logic [NUM_RS-1:0] avail;
  logic [PTR_W-1:0] ptr, winner;
  logic [DATA_W+TAG_W-1:0] res_j, res_k;
  logic             unused_bits;

  assign opcode      = Instrucao_Despachada[OP_LSB +: FIELD_W];
  assign ri          = Instrucao_Despachada[RI_LSB +: FIELD_W];
  assign rj          = Instrucao_Despachada[RJ_LSB +: FIELD_W];
  assign rk          = Instrucao_Despachada[RK_LSB +: FIELD_W];
  assign unused_bits = ^Instrucao_Despachada[3:0];
  assign is_nop      = (opcode == OP_NOP);

  // Busy_RS lags one cycle behind our own strobe, so last cycle's station is masked out.
  assign avail = ~Busy_RS & ~Enable_VQ;

  seletor_rr #(.N(NUM_RS), .PTR_W(PTR_W)) u_seletor (
    .mask  (avail),
    .ptr   (ptr),
    .found (found),
    .index (winner)
  );

  assign Pop      = Inst_Valid & ~Reset & (is_nop | found);
  assign dispatch = Inst_Valid & ~Reset & ~is_nop & found;
  assign stall    = Inst_Valid & ~Reset & ~is_nop & ~found;

  // A register renamed last cycle is not yet visible in Rs_Qi; forward that mapping first.
  function automatic logic [DATA_W+TAG_W-1:0] resolve(input logic [2:0] src);
    logic [TAG_W-1:0] t;
    t = Rs_Qi[int'(src)*TAG_W +: TAG_W];
    if (R_enable_despacho && (R_target_despacho == src))
      return {V_SEM_VALOR, R_res_station_despacho};
    else if ((t != TAG_W'(FREE_REGISTER)) && CDB_Valid && (CDB_Tag == t))
      return {CDB_Data, TAG_W'(FREE_REGISTER)};
    else if (t != TAG_W'(FREE_REGISTER))
      return {V_SEM_VALOR, t};
    else
      return {Rs_Qi_data[int'(src)*DATA_W +: DATA_W], TAG_W'(FREE_REGISTER)};
  endfunction

  assign res_j = resolve(rj);
  assign res_k = resolve(rk);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      Vj                     <= V_SEM_VALOR;
      Vk                     <= V_SEM_VALOR;
      Qj                     <= '0;
      Qk                     <= '0;
      Ufop                   <= '0;
      Enable_VQ              <= '0;
      R_enable_despacho      <= 1'b0;
      R_target_despacho      <= '0;
      R_res_station_despacho <= '0;
      Stall_Count            <= '0;
      ptr                    <= '0;
    end else begin
      Enable_VQ         <= '0;
      R_enable_despacho <= 1'b0;
      if (dispatch) begin
        {Vj, Qj}               <= res_j;
        {Vk, Qk}               <= res_k;
        Ufop                   <= opcode;
        Enable_VQ              <= NUM_RS'(1) << winner;
        R_enable_despacho      <= 1'b1;
        R_target_despacho      <= ri;
        R_res_station_despacho <= TAG_W'(winner) + TAG_W'(1);
        ptr                    <= (int'(winner) == NUM_RS - 1) ? '0 : winner + PTR_W'(1);
      end
      if (stall && (Stall_Count != 16'hFFFF))
        Stall_Count <= Stall_Count + 16'd1;
    end
  end
endmodule

// File: tb/tb_unidade_despacho_param.sv
// Directed bench for unidade_despacho_param: reset, dispatch, forwarding,
// CDB capture, stall, NOP and mid-stream reset.
module tb_unidade_despacho_param;
  logic         clk;
  logic         rst;
  logic         iv;
  logic [15:0]  instr;
  logic         pop;
  logic [23:0]  qi;
  logic [127:0] qd;
  logic [3:0]   busy;
  logic         cv;
  logic [2:0]   ct;
  logic [15:0]  cd;
  logic [15:0]  vj, vk;
  logic [2:0]   qj, qk;
  logic [2:0]   ufop;
  logic [3:0]   en_vq;
  logic         r_en;
  logic [2:0]   r_tgt;
  logic [2:0]   r_rs;
  logic [15:0]  stall_cnt;

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  unidade_despacho_param dut (
    .Clock                  (clk),
    .Reset                  (rst),
    .Inst_Valid             (iv),
    .Instrucao_Despachada   (instr),
    .Pop                    (pop),
    .Rs_Qi                  (qi),
    .Rs_Qi_data             (qd),
    .Busy_RS                (busy),
    .CDB_Valid              (cv),
    .CDB_Tag                (ct),
    .CDB_Data               (cd),
    .Vj                     (vj),
    .Vk                     (vk),
    .Qj                     (qj),
    .Qk                     (qk),
    .Ufop                   (ufop),
    .Enable_VQ              (en_vq),
    .R_enable_despacho      (r_en),
    .R_target_despacho      (r_tgt),
    .R_res_station_despacho (r_rs),
    .Stall_Count            (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_reg(input int idx, input logic [2:0] tag, input logic [15:0] data);
    qi[idx*3 +: 3]   = tag;
    qd[idx*16 +: 16] = data;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; iv = 1'b0; instr = '0; qi = '0; qd = '0;
    busy = '0; cv = 1'b0; ct = '0; cd = '0;
    tick(); tick();
    chk("rst_vj", 32'(vj), 32'hFFF0);
    chk("rst_vk", 32'(vk), 32'hFFF0);
    chk("rst_qj", 32'(qj), 32'h0);
    chk("rst_qk", 32'(qk), 32'h0);
    chk("rst_ufop", 32'(ufop), 32'h0);
    chk("rst_en_vq", 32'(en_vq), 32'h0);
    chk("rst_r_en", 32'(r_en), 32'h0);
    chk("rst_r_rs", 32'(r_rs), 32'h0);
    chk("rst_stall", 32'(stall_cnt), 32'h0);

    // ADD R1,R2,R3 with free registers: R2=5, R3=7
    rst = 1'b0;
    set_reg(1, 3'd0, 16'h0011);
    set_reg(2, 3'd0, 16'h0005);
    set_reg(3, 3'd0, 16'h0007);
    iv = 1'b1; instr = 16'h2530;
    #1 chk("add1_pop", 32'(pop), 32'h1);
    tick();
    chk("add1_en_vq", 32'(en_vq), 32'b0001);
    chk("add1_vj", 32'(vj), 32'h0005);
    chk("add1_vk", 32'(vk), 32'h0007);
    chk("add1_qj", 32'(qj), 32'h0);
    chk("add1_r_en", 32'(r_en), 32'h1);
    chk("add1_r_tgt", 32'(r_tgt), 32'h1);
    chk("add1_r_rs", 32'(r_rs), 32'h1);
    chk("add1_ufop", 32'(ufop), 32'h1);

    // ADD R4,R1,R2 back-to-back; R1 renamed last cycle but table still stale
    instr = 16'h30A0;
    #1 chk("add2_pop", 32'(pop), 32'h1);
    tick();
    chk("add2_en_vq", 32'(en_vq), 32'b0010);
    chk("add2_r_rs", 32'(r_rs), 32'h2);
    chk("add2_r_tgt", 32'(r_tgt), 32'h4);
    chk("add2_qj", 32'(qj), 32'h1);
    chk("add2_vj", 32'(vj), 32'hFFF0);
    chk("add2_vk", 32'(vk), 32'h0005);

    // idle cycle: strobes drop, operands hold
    iv = 1'b0;
    tick();
    chk("idle_en_vq", 32'(en_vq), 32'h0);
    chk("idle_r_en", 32'(r_en), 32'h0);
    chk("idle_vj_hold", 32'(vj), 32'hFFF0);
    chk("idle_stall", 32'(stall_cnt), 32'h0);

    // SUB R5,R2,R6: R2 waits on tag 3 (on CDB now, data 9), R6 waits on tag 4
    set_reg(2, 3'd3, 16'h0005);
    set_reg(6, 3'd4, 16'h0066);
    cv = 1'b1; ct = 3'd3; cd = 16'h0009;
    iv = 1'b1; instr = 16'h5560;
    tick();
    chk("cdb_en_vq", 32'(en_vq), 32'b0100);
    chk("cdb_vj", 32'(vj), 32'h0009);
    chk("cdb_qj", 32'(qj), 32'h0);
    chk("cdb_vk", 32'(vk), 32'hFFF0);
    chk("cdb_qk", 32'(qk), 32'h4);
    chk("cdb_ufop", 32'(ufop), 32'h2);
    chk("cdb_r_rs", 32'(r_rs), 32'h3);

    // all stations busy for 5 cycles
    cv = 1'b0; busy = 4'hF; instr = 16'h2530;
    #1 chk("stall_pop", 32'(pop), 32'h0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_en_vq", 32'(en_vq), 32'h0);
    end
    chk("stall_cnt5", 32'(stall_cnt), 32'h5);

    // free station 2 (index 1); ptr=3 wraps to it
    busy = 4'b1101;
    #1 chk("free2_pop", 32'(pop), 32'h1);
    tick();
    chk("free2_en_vq", 32'(en_vq), 32'b0010);
    chk("free2_r_rs", 32'(r_rs), 32'h2);
    chk("free2_qj", 32'(qj), 32'h3);
    chk("free2_vj", 32'(vj), 32'hFFF0);
    chk("free2_vk", 32'(vk), 32'h0007);
    chk("free2_stall", 32'(stall_cnt), 32'h5);

    // NOP pops even with all stations busy
    busy = 4'hF; instr = 16'h0000;
    #1 chk("nop_pop", 32'(pop), 32'h1);
    tick();
    chk("nop_en_vq", 32'(en_vq), 32'h0);
    chk("nop_r_en", 32'(r_en), 32'h0);
    chk("nop_stall", 32'(stall_cnt), 32'h5);
    chk("nop_ufop_hold", 32'(ufop), 32'h1);

    // reset with a dispatchable instruction in flight
    busy = 4'h0; instr = 16'h2530; rst = 1'b1;
    #1 chk("mrst_pop", 32'(pop), 32'h0);
    tick();
    chk("mrst_en_vq", 32'(en_vq), 32'h0);
    chk("mrst_stall", 32'(stall_cnt), 32'h0);
    chk("mrst_qj", 32'(qj), 32'h0);
    chk("mrst_vj", 32'(vj), 32'hFFF0);
    chk("mrst_r_rs", 32'(r_rs), 32'h0);
    rst = 1'b0;
    #1 chk("post_rst_pop", 32'(pop), 32'h1);
    tick();
    chk("post_rst_en_vq", 32'(en_vq), 32'b0001);
    chk("post_rst_r_rs", 32'(r_rs), 32'h1);
    chk("post_rst_qj", 32'(qj), 32'h3);
    chk("post_rst_vk", 32'(vk), 32'h0007);
    iv = 1'b0;
    tick();
    chk("final_en_vq", 32'(en_vq), 32'h0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
